// File: rtl/io_pattern_checker.sv
// Receive-side monitor for the IO pad handshake 01..0A, all-ones, 00 with a stability filter and a timeout.
// Optional IO_CHECK_STRICT_EN: an out-of-order accepted value fails the check instead of being ignored.
module io_pattern_checker #(
  parameter int WIDTH          = 8,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             start,
  input  logic [WIDTH-1:0] io_in,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [3:0]       step,
  output logic [WIDTH-1:0] last_value
);

  localparam int HW = $clog2(STABLE_CYCLES + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(STABLE_CYCLES);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(STABLE_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYCLES);
  localparam logic [3:0]    LAST_STEP = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_PASSED,
    ST_FAILED
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] s1_reg;
  logic [WIDTH-1:0] s2_reg;
  logic [HW-1:0]    hold_reg;
  logic [TW-1:0]    tmo_reg;

  logic             accept;
  logic             match;
  logic             bad_order;
  logic [WIDTH-1:0] exp_cur;
  logic [WIDTH-1:0] exp_prev;

  function automatic logic [WIDTH-1:0] exp_value(input logic [3:0] idx);
    if (idx < 4'd10)
      return WIDTH'(idx + 4'd1);
    else if (idx == 4'd10)
      return '1;
    else
      return '0;
  endfunction

  // hold_reg = number of samples s2 has held its current value; it fires once
  // at STABLE_CYCLES and then parks one above so the same value is not re-accepted.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      s1_reg   <= '0;
      s2_reg   <= '0;
      hold_reg <= '0;
    end else begin
      s1_reg <= io_in;
      s2_reg <= s1_reg;
      if (start)
        hold_reg <= '0;
      else if (s1_reg != s2_reg)
        hold_reg <= HW'(1);
      else if (hold_reg != HOLD_SAT)
        hold_reg <= hold_reg + HW'(1);
    end
  end

  always_comb begin
    accept    = (hold_reg == HOLD_FIRE);
    exp_cur   = exp_value(step);
    exp_prev  = exp_value(step - 4'd1);
    match     = accept && (s2_reg == exp_cur);
    bad_order = accept && !match && !((step != 4'd0) && (s2_reg == exp_prev));
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      state_reg  <= ST_IDLE;
      tmo_reg    <= '0;
      busy       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      timeout    <= 1'b0;
      step       <= 4'd0;
      last_value <= '0;
    end else begin
      if (accept)
        last_value <= s2_reg;
      // start overrides everything, including a match on the same edge
      if (start) begin
        state_reg <= ST_ARMED;
        tmo_reg   <= '0;
        busy      <= 1'b1;
        pass      <= 1'b0;
        fail      <= 1'b0;
        timeout   <= 1'b0;
        step      <= 4'd0;
      end else begin
        unique case (state_reg)
          ST_ARMED: begin
            if (match) begin
              step    <= step + 4'd1;
              tmo_reg <= '0;
              if (step == LAST_STEP) begin
                state_reg <= ST_PASSED;
                busy      <= 1'b0;
                pass      <= 1'b1;
              end
            end
`ifdef IO_CHECK_STRICT_EN
            else if (bad_order) begin
              state_reg <= ST_FAILED;
              busy      <= 1'b0;
              fail      <= 1'b1;
              timeout   <= 1'b0;
            end
`endif
            else if (tmo_reg == TMO_LAST) begin
              state_reg <= ST_FAILED;
              busy      <= 1'b0;
              fail      <= 1'b1;
              timeout   <= 1'b1;
            end else if (tmo_reg != TMO_MAX) begin
              tmo_reg <= tmo_reg + TW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifndef IO_CHECK_STRICT_EN
  logic unused_strict;
  assign unused_strict = bad_order;
`endif

endmodule
